// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, 1-cycle synchronous imem request/response,
// a one-entry skid buffer for stalls, redirect flush, and a registered IF/ID output.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus_1
);

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

  logic [ADDR_W-1:0] pc_p0;
  logic              rsp_vld_p1;
  logic [ADDR_W-1:0] rsp_pc_p1;
  logic              skid_vld_p1;
  logic [DATA_W-1:0] skid_instr_p1;
  logic [ADDR_W-1:0] skid_pc_p1;
  logic              skid_load;
  logic              out_load;
  logic [DATA_W-1:0] ld_instr;
  logic [ADDR_W-1:0] ld_pc;

  assign imem_en   = !stall && !redirect_valid;
  assign imem_addr = pc_p0;

  // Stage p0: program counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_p0 <= RESET_PC;
    end else if (redirect_valid) begin
      pc_p0 <= redirect_addr;
    end else if (imem_en) begin
      pc_p0 <= pc_inc(pc_p0);
    end
  end

  // Stage p1: outstanding memory response and skid buffer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld_p1  <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else begin
      rsp_vld_p1 <= imem_en;
      if (redirect_valid) begin
        skid_vld_p1 <= 1'b0;
      end else if (stall) begin
        if (rsp_vld_p1) skid_vld_p1 <= 1'b1;
      end else begin
        skid_vld_p1 <= 1'b0;
      end
    end
  end

  assign skid_load = stall && rsp_vld_p1 && !redirect_valid;

  always_ff @(posedge clock) begin
    rsp_pc_p1 <= pc_p0;
    if (skid_load) begin
      skid_instr_p1 <= imem_rdata;
      skid_pc_p1    <= rsp_pc_p1;
    end
  end

  // Stage p2: IF/ID output register; a parked skid word is always older than a live response
  always_comb begin
    out_load = !redirect_valid && !stall && (skid_vld_p1 || rsp_vld_p1);
    ld_instr = imem_rdata;
    ld_pc    = rsp_pc_p1;
    if (skid_vld_p1) begin
      ld_instr = skid_instr_p1;
      ld_pc    = skid_pc_p1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_pc        <= '0;
      out_pc_plus_1 <= '0;
    end else begin
      if (redirect_valid) begin
        out_valid <= 1'b0;
      end else if (!stall) begin
        out_valid <= out_load;
      end
      if (out_load) begin
        out_instr     <= ld_instr;
        out_pc        <= ld_pc;
        out_pc_plus_1 <= pc_inc(ld_pc);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: abstract fetch-stream model, scoreboard queue,
// directed scenarios followed by randomized stall/redirect/reset traffic.
module tb_instruction_fetch_unit;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] RST_PC = 10'h000;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_plus_1;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] gen_pc;

  instruction_fetch_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RST_PC)
  ) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus_1(out_pc_plus_1)
  );

  always #5 clock = ~clock;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + {22'd0, a};
  endfunction

  // synchronous instruction memory, one cycle read latency
  always @(posedge clock) if (imem_en) imem_rdata <= mem_word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Each unstalled, non-redirect cycle fetches the next word of the stream;
  // a redirect drops every word not yet delivered and restarts at the target.
  task automatic step(input logic st, input logic rv, input logic [ADDR_W-1:0] ra);
    stall = st; redirect_valid = rv; redirect_addr = ra;
    @(posedge clock);
    if (reset_n) begin
      if (rv) begin
        exp_q.delete();
        gen_pc = ra;
      end else if (!st) begin
        exp_q.push_back(gen_pc);
        gen_pc = gen_pc + 10'd1;
      end
    end
    #1;
  endtask

  task automatic async_reset_pulse();
    #2 reset_n = 1'b0;
    exp_q.delete();
    gen_pc = RST_PC;
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_pc", {22'd0, imem_addr}, {22'd0, RST_PC});
    #3 reset_n = 1'b1;
  endtask

  // monitor: a word is new when out_valid is set after an unstalled edge
  initial begin : monitor
    logic              new_out;
    logic [ADDR_W-1:0] p;
    forever begin
      @(posedge clock);
      new_out = !stall;
      @(negedge clock);
      if (out_valid && new_out) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_out: got pc %h expected no output", out_pc);
        end else begin
          p = exp_q.pop_front();
          chk("out_pc", {22'd0, out_pc}, {22'd0, p});
          chk("out_instr", out_instr, mem_word(p));
          chk("out_pc_plus_1", {22'd0, out_pc_plus_1}, {22'd0, p + 10'd1});
        end
      end
    end
  end

  initial begin : stim
    int guard;
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    gen_pc = RST_PC;
    #7;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", {22'd0, out_pc}, 32'd0);
    chk("rst_out_pc_plus_1", {22'd0, out_pc_plus_1}, 32'd0);
    chk("rst_imem_addr", {22'd0, imem_addr}, {22'd0, RST_PC});
    chk("rst_imem_en", {31'd0, imem_en}, 32'd1);
    #5 reset_n = 1'b1;

    // stream start: first valid word at the second edge
    step(0, 0, '0);
    chk("first_edge_valid", {31'd0, out_valid}, 32'd0);
    step(0, 0, '0);
    chk("second_edge_valid", {31'd0, out_valid}, 32'd1);
    chk("second_edge_pc", {22'd0, out_pc}, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    chk("pre_stall_pc", {22'd0, out_pc}, 32'd5);

    // stall three cycles, word 6 parks in the skid buffer
    for (int i = 0; i < 3; i++) begin
      step(1, 0, '0);
      chk("stall_imem_en", {31'd0, imem_en}, 32'd0);
      chk("stall_hold_pc", {22'd0, out_pc}, 32'd5);
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0);
      chk("post_stall_pc", {22'd0, out_pc}, 32'd6 + i);
    end
    step(0, 0, '0);
    step(0, 0, '0);
    chk("pre_redirect_pc", {22'd0, out_pc}, 32'd10);

    // redirect to 0x200
    step(0, 1, 10'h200);
    chk("redir_gap1", {31'd0, out_valid}, 32'd0);
    step(0, 0, '0);
    chk("redir_gap2", {31'd0, out_valid}, 32'd0);
    step(0, 0, '0);
    chk("redir_target_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_target_pc", {22'd0, out_pc}, 32'h200);
    step(0, 0, '0);
    chk("redir_next_pc", {22'd0, out_pc}, 32'h201);

    // redirect while stalled with the skid full
    step(1, 0, '0);
    step(1, 0, '0);
    step(1, 1, 10'h040);
    chk("skid_redir_gap1", {31'd0, out_valid}, 32'd0);
    step(0, 0, '0);
    chk("skid_redir_gap2", {31'd0, out_valid}, 32'd0);
    step(0, 0, '0);
    chk("skid_redir_pc", {22'd0, out_pc}, 32'h040);

    // address wrap
    step(0, 1, 10'h3FE);
    step(0, 0, '0);
    step(0, 0, '0);
    chk("wrap_pc0", {22'd0, out_pc}, 32'h3FE);
    step(0, 0, '0);
    chk("wrap_pc1_plus1", {22'd0, out_pc_plus_1}, 32'h000);
    step(0, 0, '0);
    chk("wrap_pc2", {22'd0, out_pc}, 32'h000);

    // asynchronous reset when out_pc reaches 7
    guard = 0;
    while (!(out_valid && out_pc == 10'd7) && guard < 40) begin
      step(0, 0, '0);
      guard++;
    end
    chk("reach_pc7", {31'd0, out_valid && out_pc == 10'd7}, 32'd1);
    async_reset_pulse();
    step(0, 0, '0);
    chk("restart_edge1_valid", {31'd0, out_valid}, 32'd0);
    step(0, 0, '0);
    chk("restart_edge2_pc", {22'd0, out_pc}, {22'd0, RST_PC});
    chk("restart_edge2_valid", {31'd0, out_valid}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           ADDR_W'($urandom));
    end

    // free run: exactly one fetched word still in flight after each delivery
    for (int i = 0; i < 5; i++) step(0, 0, '0);
    #5;
    chk("in_flight_count", exp_q.size(), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
